quad_decoder: RTL and testbench

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_decoder.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_quad_decoder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
`default_nettype none
// ============================================================================
// Module   : quad_decoder
// Purpose  : Rotary-encoder front end. Synchronizes and debounces the raw
//            A/B quadrature channels and a push-button, decodes full
//            detent cycles into a bounded position counter, and reports
//            illegal quadrature transitions.
// Ports    : clk        - system clock, all logic on the rising edge
//            rst_n      - synchronous active-low reset
//            a_in, b_in - raw encoder channels (asynchronous, idle high)
//            btn_in     - raw push-button (asynchronous, active high)
//            clr        - synchronous count clear (active high)
//            count      - position, 0..CNT_MAX
//            dir        - direction of last counted step (1 = increment)
//            step       - one-cycle pulse per counted detent
//            btn_press  - one-cycle pulse per debounced button press
//            err        - one-cycle pulse on an illegal A/B transition
// Revision : 1.0 - initial release
// ============================================================================
module quad_decoder #(
  parameter int CNT_W      = 5,
  parameter int CNT_MAX    = 19,
  parameter int DEB_CYCLES = 4,
  parameter int WRAP       = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             btn_in,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             btn_press,
  output logic             err
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int N_CH   = 3;
  localparam int CH_A   = 0;
  localparam int CH_B   = 1;
  localparam int CH_BTN = 2;

  // Debounce run counter only needs to reach DEB_CYCLES-1: the cycle that
  // would make it DEB_CYCLES is the one that updates the filtered value.
  localparam int               DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  // Idle levels of each channel: A and B rest high, button rests low.
  localparam logic [N_CH-1:0]  IDLE_LVL = 3'b011;

  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(CNT_MAX);

  // --------------------------------------------------------------------------
  // Parameter legality
  // --------------------------------------------------------------------------
  if ((CNT_MAX < 0) || (longint'(CNT_MAX) >= (longint'(1) << CNT_W))) begin : g_bad_cnt_max
    $error("quad_decoder: CNT_MAX must lie in 0 .. 2**CNT_W-1");
  end

  if (DEB_CYCLES < 1) begin : g_bad_deb_cycles
    $error("quad_decoder: DEB_CYCLES must be at least 1");
  end

  // --------------------------------------------------------------------------
  // Input conditioning: 2-flop synchronizer followed by a debounce filter,
  // one identical lane per raw input.
  // --------------------------------------------------------------------------
  logic [N_CH-1:0] raw_in;
  logic [N_CH-1:0] filt;

  assign raw_in = {btn_in, b_in, a_in};

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_chan
    logic             sync1_q;
    logic             sync2_q;
    logic             filt_q;
    logic             filt_d;
    logic [DEB_W-1:0] deb_cnt_q;
    logic [DEB_W-1:0] deb_cnt_d;

    // The run counter tracks how many consecutive cycles the synchronized
    // value has disagreed with the filtered value. Any agreeing cycle
    // (a glitch back to the old level) clears the run.
    always_comb begin
      filt_d    = filt_q;
      deb_cnt_d = '0;
      if (sync2_q != filt_q) begin
        if (deb_cnt_q == DEB_LAST) begin
          filt_d = sync2_q;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync1_q   <= IDLE_LVL[ch];
        sync2_q   <= IDLE_LVL[ch];
        filt_q    <= IDLE_LVL[ch];
        deb_cnt_q <= '0;
      end else begin
        sync1_q   <= raw_in[ch];
        sync2_q   <= sync1_q;
        filt_q    <= filt_d;
        deb_cnt_q <= deb_cnt_d;
      end
    end

    assign filt[ch] = filt_q;
  end

  // --------------------------------------------------------------------------
  // Quadrature decoder and position counter
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_R1   = 3'd1,
    S_R2   = 3'd2,
    S_R3   = 3'd3,
    S_L1   = 3'd4,
    S_L2   = 3'd5,
    S_L3   = 3'd6
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [N_CH-1:0] filt_prev_q;
  logic [N_CH-1:0] filt_prev_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic            dir_q;
  logic            dir_d;
  logic            step_q;
  logic            step_d;
  logic            btn_press_q;
  logic            btn_press_d;
  logic            err_q;
  logic            err_d;

  logic            fa;
  logic            fb;
  logic            illegal;
  logic            inc_ev;
  logic            dec_ev;

  assign fa = filt[CH_A];
  assign fb = filt[CH_B];

  always_comb begin
    state_d     = state_q;
    filt_prev_d = filt;
    count_d     = count_q;
    dir_d       = dir_q;
    inc_ev      = 1'b0;
    dec_ev      = 1'b0;

    // Both filtered channels changing on the same edge means a phase was
    // skipped, so the direction cannot be trusted.
    illegal = (fa ^ filt_prev_q[CH_A]) & (fb ^ filt_prev_q[CH_B]);

    if (illegal) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fb) begin
            state_d = S_R1;
          end else if (!fa) begin
            state_d = S_L1;
          end
        end
        S_R1: begin
          if (fb) begin
            state_d = S_IDLE;
          end else if (!fa) begin
            state_d = S_R2;
          end
        end
        S_R2: begin
          if (fa) begin
            state_d = S_R1;
          end else if (fb) begin
            state_d = S_R3;
          end
        end
        S_R3: begin
          if (!fb) begin
            state_d = S_R2;
          end else if (fa) begin
            state_d = S_IDLE;
            inc_ev  = 1'b1;
          end
        end
        S_L1: begin
          if (fa) begin
            state_d = S_IDLE;
          end else if (!fb) begin
            state_d = S_L2;
          end
        end
        S_L2: begin
          if (fb) begin
            state_d = S_L1;
          end else if (fa) begin
            state_d = S_L3;
          end
        end
        S_L3: begin
          if (!fa) begin
            state_d = S_L2;
          end else if (fb) begin
            state_d = S_IDLE;
            dec_ev  = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Position update; a saturated hold still counts as an event.
    if (inc_ev) begin
      dir_d = 1'b1;
      if (count_q == CNT_TOP) begin
        count_d = (WRAP != 0) ? '0 : count_q;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (dec_ev) begin
      dir_d = 1'b0;
      if (count_q == '0) begin
        count_d = (WRAP != 0) ? CNT_TOP : count_q;
      end else begin
        count_d = count_q - CNT_W'(1);
      end
    end

    // Clear wins over a coincident event for the count only; dir and step
    // still describe the event.
    if (clr) begin
      count_d = '0;
    end

    step_d      = inc_ev | dec_ev;
    err_d       = illegal;
    btn_press_d = filt[CH_BTN] & ~filt_prev_q[CH_BTN];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      filt_prev_q <= IDLE_LVL;
      count_q     <= '0;
      dir_q       <= 1'b0;
      step_q      <= 1'b0;
      btn_press_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      filt_prev_q <= filt_prev_d;
      count_q     <= count_d;
      dir_q       <= dir_d;
      step_q      <= step_d;
      btn_press_q <= btn_press_d;
      err_q       <= err_d;
    end
  end

  assign count     = count_q;
  assign dir       = dir_q;
  assign step      = step_q;
  assign btn_press = btn_press_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_quad_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad_decoder
// Purpose  : Self-checking bench for quad_decoder. Two instances (wrapping
//            and saturating) share the stimulus; a detent-level model
//            predicts every output each cycle, and directed scenarios pin
//            hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_quad_decoder;

  localparam int CNT_W   = 5;
  localparam int CNT_MAX = 19;
  localparam int DEB     = 4;
  localparam int HOLD    = DEB + 6;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic a_in   = 1'b1;
  logic b_in   = 1'b1;
  logic btn_in = 1'b0;
  logic clr    = 1'b0;

  logic [CNT_W-1:0] count_w, count_s;
  logic dir_w, dir_s, step_w, step_s, btnp_w, btnp_s, err_w, err_s;

  quad_decoder #(.CNT_W(CNT_W), .CNT_MAX(CNT_MAX), .DEB_CYCLES(DEB), .WRAP(1)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .btn_in(btn_in), .clr(clr),
    .count(count_w), .dir(dir_w), .step(step_w), .btn_press(btnp_w), .err(err_w)
  );

  quad_decoder #(.CNT_W(CNT_W), .CNT_MAX(CNT_MAX), .DEB_CYCLES(DEB), .WRAP(0)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .btn_in(btn_in), .clr(clr),
    .count(count_s), .dir(dir_s), .step(step_s), .btn_press(btnp_s), .err(err_s)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // --------------------------------------------------------------------------
  // Model. Raw samples are kept in a history; a filtered level flips when
  // the last DEB samples the filter could have seen (raw delayed by two
  // edges) all disagree with it. Decoding is tracked as "which way did we
  // leave the rest position" plus the level pair we came from when
  // returning to rest.
  // --------------------------------------------------------------------------
  bit        h [3][DEB+2];
  bit [2:0]  mf, mp;          // filtered levels {btn,b,a} and previous cycle
  int        mode;            // 0 = at rest, 1 = right excursion, 2 = left
  int        mcount_w, mcount_s;
  bit        mdir, mstep, merr, mbtnp;

  always @(posedge clk) begin
    bit ta, tb, ev_inc, ev_dec, all_diff;
    if (!rst_n) begin
      for (int c = 0; c < 3; c++)
        for (int k = 0; k < DEB+2; k++) h[c][k] = (c != 2);
      mf = 3'b011; mp = 3'b011; mode = 0;
      mcount_w = 0; mcount_s = 0;
      mdir = 0; mstep = 0; merr = 0; mbtnp = 0;
    end else begin
      ta = mf[0] != mp[0];
      tb = mf[1] != mp[1];
      ev_inc = 0; ev_dec = 0;
      merr = ta && tb;
      if (merr) begin
        mode = 0;
      end else if (mode == 0) begin
        if (!(mf[0] && mf[1])) mode = (mf[1] == 0) ? 1 : 2;
      end else if (mf[0] && mf[1]) begin
        ev_inc = (mode == 1) && (mp[1:0] == 2'b10);   // came from a=0,b=1
        ev_dec = (mode == 2) && (mp[1:0] == 2'b01);   // came from a=1,b=0
        mode = 0;
      end
      mbtnp = mf[2] && !mp[2];
      mstep = ev_inc || ev_dec;
      if (ev_inc) begin
        mdir = 1;
        mcount_w = (mcount_w == CNT_MAX) ? 0 : mcount_w + 1;
        mcount_s = (mcount_s == CNT_MAX) ? CNT_MAX : mcount_s + 1;
      end else if (ev_dec) begin
        mdir = 0;
        mcount_w = (mcount_w == 0) ? CNT_MAX : mcount_w - 1;
        mcount_s = (mcount_s == 0) ? 0 : mcount_s - 1;
      end
      if (clr) begin
        mcount_w = 0;
        mcount_s = 0;
      end
      mp = mf;
      for (int c = 0; c < 3; c++) begin
        for (int k = DEB+1; k > 0; k--) h[c][k] = h[c][k-1];
      end
      h[0][0] = a_in; h[1][0] = b_in; h[2][0] = btn_in;
      for (int c = 0; c < 3; c++) begin
        all_diff = 1;
        for (int k = 2; k <= DEB+1; k++) if (h[c][k] == mf[c]) all_diff = 0;
        if (all_diff) mf[c] = !mf[c];
      end
    end
  end

  // Per-cycle comparison against the model, plus pulse counters.
  int n_step_w = 0, n_step_s = 0, n_err = 0, n_btnp = 0;

  always @(negedge clk) begin
    if (checking) begin
      chk("count_wrap", int'(count_w), mcount_w);
      chk("count_sat",  int'(count_s), mcount_s);
      chk("dir_wrap",   int'(dir_w),   int'(mdir));
      chk("dir_sat",    int'(dir_s),   int'(mdir));
      chk("step_wrap",  int'(step_w),  int'(mstep));
      chk("step_sat",   int'(step_s),  int'(mstep));
      chk("err_wrap",   int'(err_w),   int'(merr));
      chk("err_sat",    int'(err_s),   int'(merr));
      chk("btnp_wrap",  int'(btnp_w),  int'(mbtnp));
      chk("btnp_sat",   int'(btnp_s),  int'(mbtnp));
      if (step_w) n_step_w++;
      if (step_s) n_step_s++;
      if (err_w)  n_err++;
      if (btnp_w) n_btnp++;
    end
  end

  task automatic right_cycle();
    b_in = 0; tick(HOLD);
    a_in = 0; tick(HOLD);
    b_in = 1; tick(HOLD);
    a_in = 1; tick(HOLD);
  endtask

  task automatic left_cycle();
    a_in = 0; tick(HOLD);
    b_in = 0; tick(HOLD);
    a_in = 1; tick(HOLD);
    b_in = 1; tick(HOLD);
  endtask

  task automatic do_reset();
    rst_n = 0; tick(3);
    rst_n = 1; tick(HOLD);
  endtask

  initial begin
    int s0, s1, e0, p0;

    // Reset state
    rst_n = 0;
    tick(2);
    checking = 1;
    tick(1);
    chk("rst_count", int'(count_w), 0);
    chk("rst_dir",   int'(dir_w),   0);
    chk("rst_step",  int'(step_w),  0);
    chk("rst_err",   int'(err_w),   0);
    chk("rst_btnp",  int'(btnp_w),  0);
    rst_n = 1;
    tick(HOLD);

    // One right detent, with latency from A rising
    s0 = n_step_w;
    b_in = 0; tick(HOLD);
    a_in = 0; tick(HOLD);
    b_in = 1; tick(HOLD);
    a_in = 1;
    tick(6);
    chk("lat_step_early",  int'(step_w),  0);
    chk("lat_count_early", int'(count_w), 0);
    tick(1);
    chk("lat_step",  int'(step_w),  1);
    chk("lat_count", int'(count_w), 1);
    chk("lat_dir",   int'(dir_w),   1);
    tick(1);
    chk("lat_step_one_cycle", int'(step_w), 0);
    tick(HOLD);
    chk("right_one_step", n_step_w - s0, 1);
    chk("model_after_right", mcount_w, 1);

    // Short glitches on A while at rest
    s0 = n_step_w; e0 = n_err;
    for (int i = 0; i < 3; i++) begin
      a_in = 0; tick(2);
      a_in = 1; tick(8);
    end
    tick(HOLD);
    chk("glitch_count", int'(count_w), 1);
    chk("glitch_steps", n_step_w - s0, 0);
    chk("glitch_errs",  n_err - e0, 0);

    // Both channels falling together, then rising together
    s0 = n_step_w; e0 = n_err;
    a_in = 0; b_in = 0; tick(HOLD);
    chk("illegal_err_once", n_err - e0, 1);
    chk("illegal_count",    int'(count_w), 1);
    a_in = 1; b_in = 1; tick(HOLD);
    chk("illegal_err_back", n_err - e0, 2);
    chk("illegal_no_step",  n_step_w - s0, 0);
    chk("illegal_count2",   int'(count_w), 1);

    // Left detents: 1 -> 0, then underflow
    left_cycle();
    chk("left_count_w", int'(count_w), 0);
    chk("left_dir",     int'(dir_w),   0);
    s1 = n_step_s;
    left_cycle();
    chk("under_wrap", int'(count_w), 19);
    chk("under_sat",  int'(count_s), 0);
    chk("under_sat_step", n_step_s - s1, 1);
    right_cycle();
    chk("over_back_wrap", int'(count_w), 0);
    chk("over_back_sat",  int'(count_s), 1);

    // Overflow at CNT_MAX
    do_reset();
    for (int i = 0; i < 19; i++) right_cycle();
    chk("reach_max_w", int'(count_w), 19);
    chk("reach_max_s", int'(count_s), 19);
    s1 = n_step_s;
    right_cycle();
    chk("over_wrap", int'(count_w), 0);
    chk("over_sat",  int'(count_s), 19);
    chk("over_sat_step", n_step_s - s1, 1);
    chk("over_dir", int'(dir_s), 1);
    left_cycle();
    chk("after_over_w", int'(count_w), 19);
    chk("after_over_s", int'(count_s), 18);

    // Clear coinciding with an increment at count 7
    do_reset();
    for (int i = 0; i < 7; i++) right_cycle();
    chk("pre_clr_count", int'(count_w), 7);
    b_in = 0; tick(HOLD);
    a_in = 0; tick(HOLD);
    b_in = 1; tick(HOLD);
    a_in = 1; tick(6);
    clr = 1; tick(1);
    clr = 0;
    chk("clr_count_w", int'(count_w), 0);
    chk("clr_count_s", int'(count_s), 0);
    chk("clr_step",    int'(step_w),  1);
    chk("clr_dir",     int'(dir_w),   1);
    tick(HOLD);

    // Button held ~100 cycles with bounce at both edges
    p0 = n_btnp;
    btn_in = 1; tick(1); btn_in = 0; tick(1);
    btn_in = 1; tick(2); btn_in = 0; tick(1);
    btn_in = 1; tick(100);
    btn_in = 0; tick(1); btn_in = 1; tick(2);
    btn_in = 0; tick(1); btn_in = 1; tick(1);
    btn_in = 0; tick(20);
    chk("btn_one_press", n_btnp - p0, 1);

    // Reset during a nearly finished right detent
    right_cycle();
    chk("pre_rst_count", int'(count_w), 1);
    b_in = 0; tick(HOLD);
    a_in = 0; tick(HOLD);
    b_in = 1; tick(HOLD);
    rst_n = 0; tick(3);
    rst_n = 1;
    s0 = n_step_w;
    tick(HOLD);
    a_in = 1; tick(2 * HOLD);
    chk("midrst_count", int'(count_w), 0);
    chk("midrst_steps", n_step_w - s0, 0);

    checking = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
